// File: rtl/frame_addr_gen_pkg.sv
// rtl/frame_addr_gen_pkg.sv - FSM state type, default geometry and window helper for frame_addr_gen
package frame_addr_pkg;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    IN_FRAME   = 1'b1
  } state_t;

  localparam int DEFAULT_IMAGE_W    = 160;
  localparam int DEFAULT_IMAGE_H    = 120;
  localparam int DEFAULT_SCALE_LOG2 = 1;
  localparam int DEFAULT_ADDR_W     = 16;

  // Replication counters only ever count to 2^SCALE_LOG2-1 with SCALE_LOG2 <= 2.
  localparam int REP_W = 2;

  // First coordinate past the on-screen window along one axis.
  function automatic logic [31:0] win_end(input int off, input int len, input int scale);
    return 32'(off + (len << scale));
  endfunction

endpackage

// File: rtl/frame_addr_gen_axis_window.sv
// rtl/frame_addr_gen_axis_window.sv - one window axis: range compare, replication counter, strided index
module axis_window
  import frame_addr_pkg::*;
#(
  parameter int OFF        = 0,
  parameter int LEN        = DEFAULT_IMAGE_W,
  parameter int SCALE_LOG2 = DEFAULT_SCALE_LOG2,
  parameter int STRIDE     = 1,
  parameter int IDX_W      = DEFAULT_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [9:0]       pos,
  input  logic             clear,
  input  logic             step,
  output logic             in_range,
  output logic [IDX_W-1:0] idx
);

  localparam logic [31:0]      LO      = 32'(OFF);
  localparam logic [31:0]      SPAN    = win_end(OFF, LEN, SCALE_LOG2) - LO;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'((1 << SCALE_LOG2) - 1);
  localparam logic [IDX_W-1:0] STEP_V  = IDX_W'(STRIDE);

  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_cur;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_cur;

  // The index seen by the current tick already reflects a clear on that same tick.
  always_comb begin
    in_range = (32'(pos) - LO) < SPAN;
    rep_cur  = clear ? '0 : rep_q;
    idx_cur  = clear ? '0 : idx_q;
  end

  assign idx = idx_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
      idx_q <= '0;
    end else if (en) begin
      if (step) begin
        if (rep_cur == REP_MAX) begin
          rep_q <= '0;
          idx_q <= idx_cur + STEP_V;
        end else begin
          rep_q <= rep_cur + REP_W'(1);
          idx_q <= idx_cur;
        end
      end else if (clear) begin
        rep_q <= '0;
        idx_q <= '0;
      end
    end
  end

endmodule

// File: rtl/frame_addr_gen.sv
// rtl/frame_addr_gen.sv - framebuffer read address generator for a scaled window; FRAME_ADDR_GEN_MIRROR_EN adds horizontal mirror
module frame_addr_gen
  import frame_addr_pkg::*;
#(
  parameter int IMAGE_W    = DEFAULT_IMAGE_W,
  parameter int IMAGE_H    = DEFAULT_IMAGE_H,
  parameter int SCALE_LOG2 = DEFAULT_SCALE_LOG2,
  parameter int X_OFF      = 0,
  parameter int Y_OFF      = 0,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        h,
  input  logic [9:0]        v,
`ifdef FRAME_ADDR_GEN_MIRROR_EN
  input  logic              mirror,
`endif
  output logic [ADDR_W-1:0] address,
  output logic              addr_valid,
  output logic              frame_start,
  output logic              line_start
);

  localparam logic [31:0] H_LAST = win_end(X_OFF, IMAGE_W, SCALE_LOG2) - 32'd1;
  localparam logic [31:0] V_END  = win_end(Y_OFF, IMAGE_H, SCALE_LOG2);

  state_t            state;
  logic              fs_hit;
  logic              in_frame_now;
  logic              h_in;
  logic              v_in;
  logic              h_first;
  logic              h_last;
  logic              v_past;
  logic              v_step;
  logic              pix_valid;
  logic [ADDR_W-1:0] col_idx;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_term;

  always_comb begin
    fs_hit       = (h == '0) && (v == '0);
    in_frame_now = fs_hit || (state == IN_FRAME);
    h_first      = (32'(h) == 32'(X_OFF));
    h_last       = (32'(h) == H_LAST);
    v_past       = (32'(v) >= V_END);
    v_step       = in_frame_now && v_in && h_last;
    pix_valid    = in_frame_now && h_in && v_in;
  end

  axis_window #(
    .OFF       (X_OFF),
    .LEN       (IMAGE_W),
    .SCALE_LOG2(SCALE_LOG2),
    .STRIDE    (1),
    .IDX_W     (ADDR_W)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (pix_en),
    .pos     (h),
    .clear   (h_first),
    .step    (h_in),
    .in_range(h_in),
    .idx     (col_idx)
  );

  // Row index advances by a whole image line, so its count is the row base address.
  axis_window #(
    .OFF       (Y_OFF),
    .LEN       (IMAGE_H),
    .SCALE_LOG2(SCALE_LOG2),
    .STRIDE    (IMAGE_W),
    .IDX_W     (ADDR_W)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (pix_en),
    .pos     (v),
    .clear   (fs_hit),
    .step    (v_step),
    .in_range(v_in),
    .idx     (row_base)
  );

`ifdef FRAME_ADDR_GEN_MIRROR_EN
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMAGE_W - 1);
  logic mirror_q;
  logic mirror_cur;
  assign mirror_cur = fs_hit ? mirror : mirror_q;
  assign col_term   = mirror_cur ? (COL_MAX - col_idx) : col_idx;
`else
  assign col_term   = col_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_FRAME;
      address     <= '0;
      addr_valid  <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
`ifdef FRAME_ADDR_GEN_MIRROR_EN
      mirror_q    <= 1'b0;
`endif
    end else if (pix_en) begin
      case (state)
        WAIT_FRAME: if (fs_hit) state <= IN_FRAME;
        IN_FRAME:   if (v_past && !fs_hit) state <= WAIT_FRAME;
        default:    state <= WAIT_FRAME;
      endcase
      address     <= pix_valid ? (row_base + col_term) : '0;
      addr_valid  <= pix_valid;
      frame_start <= fs_hit;
      line_start  <= in_frame_now && v_in && h_first;
`ifdef FRAME_ADDR_GEN_MIRROR_EN
      mirror_q    <= mirror_cur;
`endif
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// tb/tb_frame_addr_gen.sv - directed self-checking bench for frame_addr_gen (FRAME_ADDR_GEN_MIRROR_EN adds a mirrored instance)
module tb_frame_addr_gen;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic [9:0] h;
  logic [9:0] v;

  logic [15:0] a0, a1;
  logic        vl0, vl1, fs0, fs1, ls0, ls1;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FRAME_ADDR_GEN_MIRROR_EN
  logic        mirror_off = 1'b0;
  logic        mirror_on  = 1'b1;
  logic [15:0] a2;
  logic        vl2, fs2, ls2;

  frame_addr_gen dut2 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h(h), .v(v), .mirror(mirror_on),
    .address(a2), .addr_valid(vl2), .frame_start(fs2), .line_start(ls2)
  );
`endif

  frame_addr_gen dut0 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h(h), .v(v),
`ifdef FRAME_ADDR_GEN_MIRROR_EN
    .mirror(mirror_off),
`endif
    .address(a0), .addr_valid(vl0), .frame_start(fs0), .line_start(ls0)
  );

  frame_addr_gen #(.SCALE_LOG2(0), .X_OFF(240), .Y_OFF(180)) dut1 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h(h), .v(v),
`ifdef FRAME_ADDR_GEN_MIRROR_EN
    .mirror(mirror_off),
`endif
    .address(a1), .addr_valid(vl1), .frame_start(fs1), .line_start(ls1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int hh, input int vv);
    h = 10'(hh);
    v = 10'(vv);
    pix_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int hh, input int vv);
    h = 10'(hh);
    v = 10'(vv);
    pix_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    h = '0;
    v = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_addr", a0, 0);
    chk("reset_valid", vl0, 0);
    chk("reset_fs", fs0, 0);
    chk("reset_ls", ls0, 0);
    rst = 1'b0;

    tick(5, 5);
    chk("wait_valid", vl0, 0);
    chk("wait_addr", a0, 0);

    // Default geometry frame: full lines where checked, other lines only touch h=0 and h=319.
    tick(0, 0);
    chk("d_00_fs", fs0, 1);
    chk("d_00_ls", ls0, 1);
    chk("d_00_valid", vl0, 1);
    chk("d_00_addr", a0, 0);
`ifdef FRAME_ADDR_GEN_MIRROR_EN
    chk("m_00_addr", a2, 159);
`endif
    tick(1, 0);
    chk("d_10_addr", a0, 0);
    chk("d_10_fs", fs0, 0);
    for (int x = 2; x <= 318; x++) tick(x, 0);
    tick(319, 0);
    chk("d_319_0_addr", a0, 159);
    tick(320, 0);
    chk("d_320_0_valid", vl0, 0);
    chk("d_320_0_addr", a0, 0);
    tick(0, 1);
    chk("d_01_addr", a0, 0);
    chk("d_01_ls", ls0, 1);
    for (int x = 1; x <= 319; x++) tick(x, 1);
    tick(0, 2);
    tick(1, 2);
    tick(2, 2);
    chk("d_22_addr", a0, 161);
    for (int x = 3; x <= 319; x++) tick(x, 2);
    for (int y = 3; y <= 238; y++) begin
      tick(0, y);
      tick(319, y);
    end
    for (int x = 0; x <= 318; x++) tick(x, 239);
    tick(319, 239);
    chk("d_319_239_addr", a0, 19199);
    chk("d_319_239_valid", vl0, 1);
`ifdef FRAME_ADDR_GEN_MIRROR_EN
    chk("m_319_239_addr", a2, 19040);
`endif
    tick(320, 239);
    chk("d_320_239_valid", vl0, 0);
    tick(0, 240);
    chk("d_0_240_valid", vl0, 0);
    tick(5, 5);
    chk("d_back_wait_valid", vl0, 0);

    // Offset, unscaled instance.
    tick(0, 0);
    chk("o_00_fs", fs1, 1);
    chk("o_00_valid", vl1, 0);
    tick(239, 180);
    chk("o_239_180_valid", vl1, 0);
    tick(240, 180);
    chk("o_240_180_addr", a1, 0);
    chk("o_240_180_ls", ls1, 1);
    chk("o_240_180_valid", vl1, 1);
    tick(241, 180);
    chk("o_241_180_addr", a1, 1);
    chk("o_241_180_ls", ls1, 0);
    for (int x = 242; x <= 398; x++) tick(x, 180);
    tick(399, 180);
    chk("o_399_180_addr", a1, 159);
    tick(400, 180);
    chk("o_400_180_valid", vl1, 0);
    for (int y = 181; y <= 298; y++) begin
      tick(240, y);
      if (y == 181) chk("o_240_181_addr", a1, 160);
      tick(399, y);
    end
    for (int x = 240; x <= 398; x++) tick(x, 299);
    tick(399, 299);
    chk("o_399_299_addr", a1, 19199);
    tick(400, 299);
    chk("o_400_299_valid", vl1, 0);

    // Asynchronous reset in the middle of a frame.
    tick(0, 0);
    tick(319, 0);
    for (int y = 1; y <= 49; y++) begin
      tick(0, y);
      tick(319, y);
    end
    tick(0, 50);
    tick(100, 50);
    chk("r_pre_valid", vl0, 1);
    rst = 1'b1;
    #1;
    chk("r_async_valid", vl0, 0);
    chk("r_async_addr", a0, 0);
    #2;
    rst = 1'b0;
    tick(101, 50);
    chk("r_101_50_valid", vl0, 0);
    tick(319, 50);
    chk("r_319_50_valid", vl0, 0);
    chk("r_319_50_addr", a0, 0);
    tick(0, 0);
    chk("r_00_valid", vl0, 1);
    chk("r_00_fs", fs0, 1);
    tick(319, 0);
    tick(0, 1);
    tick(319, 1);
    tick(0, 2);
    tick(1, 2);
    tick(2, 2);
    chk("r_22_addr", a0, 161);

    // Ticks interleaved with idle cycles carrying unrelated coordinates.
    tick(0, 0);
    chk("e_00_fs", fs0, 1);
    idle(7, 7);
    chk("e_idle1_fs", fs0, 1);
    chk("e_idle1_valid", vl0, 1);
    tick(1, 0);
    chk("e_10_fs", fs0, 0);
    chk("e_10_addr", a0, 0);
    idle(2, 0);
    chk("e_idle2_addr", a0, 0);
    tick(2, 0);
    chk("e_20_addr", a0, 1);
    idle(319, 0);
    chk("e_idle3_addr", a0, 1);
    tick(3, 0);
    chk("e_30_addr", a0, 1);
    tick(4, 0);
    chk("e_40_addr", a0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_addr_gen.md
FRAME_ADDR_GEN -- requirements
Module: frame_addr_gen

Interface
REQ-001 Parameter IMAGE_W, 160, stored image width in pixels (1..1023).
REQ-002 Parameter IMAGE_H, 120, stored image height in lines (1..1023).
REQ-003 Parameter SCALE_LOG2, 1, pixel/line replication exponent (0..2); the on-screen window is (IMAGE_W<<SCALE_LOG2) x (IMAGE_H<<SCALE_LOG2).
REQ-004 Parameter X_OFF, 0, first on-screen column of the window.
REQ-005 Parameter Y_OFF, 0, first on-screen line of the window.
REQ-006 Parameter ADDR_W, 16, address width; IMAGE_W*IMAGE_H SHALL be at most 2^ADDR_W.
REQ-007 clk  input  1  the single system clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 pix_en  input  1  pixel tick; all state advances only on clk edges with pix_en=1.
REQ-010 h  input  10  current display column from the VGA timing counter.
REQ-011 v  input  10  current display line from the VGA timing counter.
REQ-012 address  output  ADDR_W  framebuffer read address, registered.
REQ-013 addr_valid  output  1  address refers to an in-window pixel, registered.
REQ-014 frame_start  output  1  one-tick pulse when (h,v)=(0,0) is accepted.
REQ-015 line_start  output  1  one-tick pulse when h=X_OFF on an in-window line.

Function
REQ-016 FSM states: WAIT_FRAME, IN_FRAME; reset enters WAIT_FRAME.
REQ-017 WAIT_FRAME -> IN_FRAME on a pix_en tick with h=0 and v=0; IN_FRAME -> WAIT_FRAME on a tick with v >= Y_OFF+(IMAGE_H<<SCALE_LOG2) after the last window line.
REQ-018 In WAIT_FRAME, addr_valid=0 and address=0 for every tick.
REQ-019 Pixel (h,v) is in-window iff X_OFF <= h < X_OFF+(IMAGE_W<<SCALE_LOG2) and Y_OFF <= v < Y_OFF+(IMAGE_H<<SCALE_LOG2).
REQ-020 For an in-window pixel, address = ((v-Y_OFF)>>SCALE_LOG2)*IMAGE_W + ((h-X_OFF)>>SCALE_LOG2), truncated to ADDR_W; addr_valid=1.
REQ-021 Out-of-window pixels yield address=0, addr_valid=0.
REQ-022 Latency: outputs for (h,v) sampled on pix_en tick N appear after that clk edge and hold until tick N+1; with pix_en=0 all outputs and state hold.
REQ-023 No multiplier: row base SHALL be an accumulator, +IMAGE_W once every 2^SCALE_LOG2 window lines; column counter increments once every 2^SCALE_LOG2 window pixels, cleared at each line start.
REQ-024 Row base clears to 0 on frame_start; column replication counter clears on line_start; row replication counter clears on frame_start.
REQ-025 h or v skipping/jumping (non-monotonic input) in IN_FRAME: outputs remain per REQ-020 formula only at line boundaries; bench checks monotonic timing only.
REQ-026 frame_start and line_start may assert on the same tick (X_OFF=0,Y_OFF=0).

Reset
REQ-027 On rst=1 asynchronously: state=WAIT_FRAME, address=0, addr_valid=0, frame_start=0, line_start=0, all counters and row base=0.
REQ-028 Reset mid-frame discards progress; valid output resumes only after the next (0,0) tick.

Configuration
REQ-029 Macro FRAME_ADDR_GEN_MIRROR_EN defined: extra input port mirror (1 bit); when mirror=1 the column term of REQ-020 becomes IMAGE_W-1-((h-X_OFF)>>SCALE_LOG2), sampled at frame_start and held for the frame.
REQ-030 Macro undefined: no mirror port; column term per REQ-020 always.

Structure
REQ-031 Package frame_addr_pkg SHALL hold the FSM state enum and default constants IMAGE_W, IMAGE_H, SCALE_LOG2, ADDR_W.
REQ-032 Sub-module axis_window SHALL implement one axis (in-range compare, replication counter, index counter) and be instantiated twice (h and v).

Verification
REQ-033 Defaults, full frame 800x521, pix_en every cycle: (h,v)=(0,0) -> frame_start=1, address=0, addr_valid=1; (319,239) -> address=19199.
REQ-034 Defaults: (1,0) and (0,1) -> address=0; (2,2) -> address=161; (320,0) -> addr_valid=0, address=0.
REQ-035 SCALE_LOG2=0, X_OFF=240, Y_OFF=180: (239,180) -> valid=0; (240,180) -> address=0, line_start=1; (399,299) -> address=19199.
REQ-036 Assert rst at (100,50) mid-frame, release; ticks before next (0,0) -> addr_valid=0; after (0,0) addresses match REQ-020.
REQ-037 pix_en toggling 1/0: outputs change only after pix_en=1 edges; sequence identical to continuous case.
REQ-038 MIRROR_EN, mirror=1, defaults: (0,0) -> address=159; (319,239) -> address=19040.
